// File: rtl/bus_arbiter.sv
// Bus ownership sequencer for the Atari7800: halts the 6502 on a read boundary, grants the
// address/data bus to MARIA DMA or the loader, and steers the memory clock accordingly.
module bus_arbiter #(
   parameter int unsigned SETTLE  = 1,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       sysclk,
   input  logic       reset_n,
   input  logic       cpu_phase,
   input  logic       cpu_rw,
   input  logic       dma_req,
   input  logic       dma_done,
   input  logic       load_req,
   output logic       halt_b,
   output logic       dma_gnt,
   output logic       load_gnt,
   output logic [1:0] owner,
   output logic       memclk_sel,
   output logic [7:0] dma_len,
   output logic       dma_timeout
);

   typedef enum logic [2:0] {
      ST_CPU,
      ST_HALT_WAIT,
      ST_SETTLE,
      ST_DMA,
      ST_HANDBACK,
      ST_LOAD
   } state_t;

   localparam logic [1:0] OWNER_CPU  = 2'd0;
   localparam logic [1:0] OWNER_DMA  = 2'd1;
   localparam logic [1:0] OWNER_LOAD = 2'd2;

   localparam logic [2:0] SETTLE_INIT = 3'(SETTLE);
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t     state, state_nx;
   logic [2:0] settle_cnt, settle_cnt_nx;
   logic [7:0] burst_cnt, burst_cnt_nx;
   logic [7:0] dma_len_nx;
   logic       dma_timeout_nx;
   logic       burst_at_limit;

   logic       halt_b_nx;
   logic       dma_gnt_nx;
   logic       load_gnt_nx;
   logic [1:0] owner_nx;
   logic       memclk_sel_nx;

   assign burst_at_limit = (burst_cnt == TIMEOUT_CNT);

   // Next-state, counters and burst statistics.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path leaves it
      // unassigned; otherwise synthesis infers a latch to hold the old value.
      state_nx       = state;
      settle_cnt_nx  = settle_cnt;
      burst_cnt_nx   = 8'd0;
      dma_len_nx     = dma_len;
      dma_timeout_nx = dma_timeout;

      if (load_req) begin
         state_nx = ST_LOAD;
      end else begin
         case (state)
            ST_CPU: begin
               if (dma_req) state_nx = ST_HALT_WAIT;
            end
            ST_HALT_WAIT: begin
               // The 6502 only honours halt on a read cycle; write strobes are skipped.
               if (!dma_req) begin
                  state_nx = ST_HANDBACK;
               end else if (cpu_phase && cpu_rw) begin
                  if (SETTLE == 0) begin
                     state_nx = ST_DMA;
                  end else begin
                     state_nx      = ST_SETTLE;
                     settle_cnt_nx = SETTLE_INIT;
                  end
               end
            end
            ST_SETTLE: begin
               if (settle_cnt <= 3'd1) state_nx = ST_DMA;
               else                    settle_cnt_nx = settle_cnt - 3'd1;
            end
            ST_DMA: begin
               if (dma_done) begin
                  state_nx = ST_HANDBACK;
               end else if (burst_at_limit) begin
                  state_nx       = ST_HANDBACK;
                  dma_timeout_nx = 1'b1;
               end
            end
            ST_HANDBACK: begin
               if (cpu_phase) state_nx = ST_CPU;
            end
            ST_LOAD: begin
               state_nx = ST_CPU;
            end
            default: begin
               state_nx = ST_CPU;
            end
         endcase
      end

      // Any exit from DMA, including a loader preempt, records the partial count.
      if (state == ST_DMA && state_nx != ST_DMA) dma_len_nx = burst_cnt;

      if (state_nx == ST_DMA) begin
         if (state != ST_DMA)          burst_cnt_nx = 8'd1;
         else if (burst_cnt == 8'hFF)  burst_cnt_nx = burst_cnt;
         else                          burst_cnt_nx = burst_cnt + 8'd1;
      end
   end

   // Outputs are decoded from the next state and registered, so they track the state
   // register exactly and dma_gnt/memclk_sel always switch on the same edge.
   always_comb begin
      halt_b_nx     = 1'b1;
      dma_gnt_nx    = 1'b0;
      load_gnt_nx   = 1'b0;
      owner_nx      = OWNER_CPU;
      memclk_sel_nx = 1'b0;
      case (state_nx)
         ST_HALT_WAIT, ST_SETTLE, ST_HANDBACK: begin
            halt_b_nx = 1'b0;
         end
         ST_DMA: begin
            halt_b_nx     = 1'b0;
            dma_gnt_nx    = 1'b1;
            owner_nx      = OWNER_DMA;
            memclk_sel_nx = 1'b1;
         end
         ST_LOAD: begin
            load_gnt_nx   = 1'b1;
            owner_nx      = OWNER_LOAD;
            memclk_sel_nx = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      if (!reset_n) begin
         state       <= ST_CPU;
         settle_cnt  <= 3'd0;
         burst_cnt   <= 8'd0;
         dma_len     <= 8'd0;
         dma_timeout <= 1'b0;
         halt_b      <= 1'b1;
         dma_gnt     <= 1'b0;
         load_gnt    <= 1'b0;
         owner       <= OWNER_CPU;
         memclk_sel  <= 1'b0;
      end else begin
         state       <= state_nx;
         settle_cnt  <= settle_cnt_nx;
         burst_cnt   <= burst_cnt_nx;
         dma_len     <= dma_len_nx;
         dma_timeout <= dma_timeout_nx;
         halt_b      <= halt_b_nx;
         dma_gnt     <= dma_gnt_nx;
         load_gnt    <= load_gnt_nx;
         owner       <= owner_nx;
         memclk_sel  <= memclk_sel_nx;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: two instances (SETTLE=1/TIMEOUT=255 and SETTLE=0/TIMEOUT=8);
// directed stimulus queues each expected output change, per-DUT monitors compare on every change.
`timescale 1ns/1ps
module tb_bus_arbiter;

   typedef struct packed {
      logic       halt_b;
      logic       dma_gnt;
      logic       load_gnt;
      logic       memclk_sel;
      logic [1:0] owner;
      logic [7:0] dma_len;
      logic       dma_timeout;
   } snap_t;

   typedef struct {
      int    cyc;
      snap_t s;
   } exp_t;

   logic sysclk = 1'b0;
   logic reset_n;
   int   cyc = 0;

   logic       a_cpu_phase, a_cpu_rw, a_dma_req, a_dma_done, a_load_req;
   logic       a_halt_b, a_dma_gnt, a_load_gnt, a_memclk_sel, a_dma_timeout;
   logic [1:0] a_owner;
   logic [7:0] a_dma_len;

   logic       b_cpu_phase, b_cpu_rw, b_dma_req, b_dma_done, b_load_req;
   logic       b_halt_b, b_dma_gnt, b_load_gnt, b_memclk_sel, b_dma_timeout;
   logic [1:0] b_owner;
   logic [7:0] b_dma_len;

   bus_arbiter #(.SETTLE(1), .TIMEOUT(255)) dut_a (
      .sysclk(sysclk), .reset_n(reset_n),
      .cpu_phase(a_cpu_phase), .cpu_rw(a_cpu_rw), .dma_req(a_dma_req),
      .dma_done(a_dma_done), .load_req(a_load_req),
      .halt_b(a_halt_b), .dma_gnt(a_dma_gnt), .load_gnt(a_load_gnt), .owner(a_owner),
      .memclk_sel(a_memclk_sel), .dma_len(a_dma_len), .dma_timeout(a_dma_timeout)
   );

   bus_arbiter #(.SETTLE(0), .TIMEOUT(8)) dut_b (
      .sysclk(sysclk), .reset_n(reset_n),
      .cpu_phase(b_cpu_phase), .cpu_rw(b_cpu_rw), .dma_req(b_dma_req),
      .dma_done(b_dma_done), .load_req(b_load_req),
      .halt_b(b_halt_b), .dma_gnt(b_dma_gnt), .load_gnt(b_load_gnt), .owner(b_owner),
      .memclk_sel(b_memclk_sel), .dma_len(b_dma_len), .dma_timeout(b_dma_timeout)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic snap_t mk(input logic h, input logic g, input logic l, input logic m,
                                input logic [1:0] o, input logic [7:0] len, input logic to);
      snap_t s;
      s.halt_b      = h;
      s.dma_gnt     = g;
      s.load_gnt    = l;
      s.memclk_sel  = m;
      s.owner       = o;
      s.dma_len     = len;
      s.dma_timeout = to;
      return s;
   endfunction

   function automatic snap_t s_idle(input logic [7:0] len, input logic to);
      return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, len, to);
   endfunction
   function automatic snap_t s_halt(input logic [7:0] len, input logic to);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, len, to);
   endfunction
   function automatic snap_t s_dma(input logic [7:0] len, input logic to);
      return mk(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, len, to);
   endfunction
   function automatic snap_t s_load(input logic [7:0] len, input logic to);
      return mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, len, to);
   endfunction

   exp_t qa[$];
   exp_t qb[$];

   task automatic push_a(input int c, input snap_t s);
      exp_t e;
      e.cyc = c;
      e.s   = s;
      qa.push_back(e);
   endtask
   task automatic push_b(input int c, input snap_t s);
      exp_t e;
      e.cyc = c;
      e.s   = s;
      qb.push_back(e);
   endtask

   // Monitors: any change of the observed outputs must match the next queued expectation.
   snap_t prev_a = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0};
   snap_t prev_b = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0};
   int    ev_a = 0;
   int    ev_b = 0;

   always @(negedge sysclk) begin
      snap_t cur;
      exp_t  e;
      cur = {a_halt_b, a_dma_gnt, a_load_gnt, a_memclk_sel, a_owner, a_dma_len, a_dma_timeout};
      if (cur !== prev_a) begin
         prev_a = cur;
         ev_a++;
         if (qa.size() == 0) begin
            n_checks++;
            $display("FAIL a_unexpected: change at cycle %0d to 0x%0h, no change required", cyc, cur);
         end else begin
            e = qa.pop_front();
            check($sformatf("a_ev%0d_cycle", ev_a), 32'(cyc), 32'(e.cyc));
            check($sformatf("a_ev%0d_outputs", ev_a), 32'(cur), 32'(e.s));
         end
      end
   end

   always @(negedge sysclk) begin
      snap_t cur;
      exp_t  e;
      cur = {b_halt_b, b_dma_gnt, b_load_gnt, b_memclk_sel, b_owner, b_dma_len, b_dma_timeout};
      if (cur !== prev_b) begin
         prev_b = cur;
         ev_b++;
         if (qb.size() == 0) begin
            n_checks++;
            $display("FAIL b_unexpected: change at cycle %0d to 0x%0h, no change required", cyc, cur);
         end else begin
            e = qb.pop_front();
            check($sformatf("b_ev%0d_cycle", ev_b), 32'(cyc), 32'(e.cyc));
            check($sformatf("b_ev%0d_outputs", ev_b), 32'(cur), 32'(e.s));
         end
      end
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic phase_a(input logic rw);
      a_cpu_phase = 1'b1;
      a_cpu_rw    = rw;
      tick();
      a_cpu_phase = 1'b0;
      a_cpu_rw    = 1'b0;
   endtask

   task automatic phase_b(input logic rw);
      b_cpu_phase = 1'b1;
      b_cpu_rw    = rw;
      tick();
      b_cpu_phase = 1'b0;
      b_cpu_rw    = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      reset_n     = 1'b1;
      a_cpu_phase = 1'b0; a_cpu_rw = 1'b0; a_dma_req = 1'b0; a_dma_done = 1'b0; a_load_req = 1'b0;
      b_cpu_phase = 1'b0; b_cpu_rw = 1'b0; b_dma_req = 1'b0; b_dma_done = 1'b0; b_load_req = 1'b0;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge sysclk);
      #2;
      check("reset_a_outputs", 32'({a_halt_b, a_dma_gnt, a_load_gnt, a_memclk_sel, a_owner,
                                    a_dma_len, a_dma_timeout}), 32'(s_idle(8'd0, 1'b0)));
      check("reset_b_outputs", 32'({b_halt_b, b_dma_gnt, b_load_gnt, b_memclk_sel, b_owner,
                                    b_dma_len, b_dma_timeout}), 32'(s_idle(8'd0, 1'b0)));
      reset_n = 1'b1;
      tick();

      // Basic burst, SETTLE=1: grant 2 cycles after the read strobe, 15 granted cycles.
      b = cyc;
      push_a(b + 1,  s_halt(8'd0, 1'b0));
      push_a(b + 6,  s_dma(8'd0, 1'b0));
      push_a(b + 21, s_halt(8'd15, 1'b0));
      push_a(b + 25, s_idle(8'd15, 1'b0));
      a_dma_req = 1'b1;
      wait_until(b + 4);  phase_a(1'b1);
      wait_until(b + 20); a_dma_done = 1'b1; tick(); a_dma_done = 1'b0; a_dma_req = 1'b0;
      wait_until(b + 24); phase_a(1'b0);
      wait_until(b + 28);

      // Write strobe skipped; strobe coincident with dma_done does not release the CPU.
      b = cyc;
      push_a(b + 1,  s_halt(8'd15, 1'b0));
      push_a(b + 9,  s_dma(8'd15, 1'b0));
      push_a(b + 13, s_halt(8'd4, 1'b0));
      push_a(b + 16, s_idle(8'd4, 1'b0));
      a_dma_req = 1'b1;
      wait_until(b + 3);  phase_a(1'b0);
      wait_until(b + 7);  phase_a(1'b1);
      wait_until(b + 12);
      a_dma_done = 1'b1; a_cpu_phase = 1'b1; a_cpu_rw = 1'b1;
      tick();
      a_dma_done = 1'b0; a_cpu_phase = 1'b0; a_cpu_rw = 1'b0; a_dma_req = 1'b0;
      wait_until(b + 15); phase_a(1'b1);
      wait_until(b + 19);

      // Loader preempts on the 3rd DMA cycle.
      b = cyc;
      push_a(b + 1,  s_halt(8'd4, 1'b0));
      push_a(b + 4,  s_dma(8'd4, 1'b0));
      push_a(b + 7,  s_load(8'd3, 1'b0));
      push_a(b + 11, s_idle(8'd3, 1'b0));
      a_dma_req = 1'b1;
      wait_until(b + 2);  phase_a(1'b1);
      wait_until(b + 6);  a_load_req = 1'b1; tick(); a_dma_req = 1'b0;
      wait_until(b + 10); a_load_req = 1'b0;
      wait_until(b + 14);

      // Request withdrawn in HALT_WAIT; a request raised during HANDBACK waits for CPU.
      b = cyc;
      push_a(b + 1,  s_halt(8'd3, 1'b0));
      push_a(b + 7,  s_idle(8'd3, 1'b0));
      push_a(b + 8,  s_halt(8'd3, 1'b0));
      push_a(b + 11, s_idle(8'd3, 1'b0));
      a_dma_req = 1'b1;
      wait_until(b + 2);  phase_a(1'b0);
      a_dma_req = 1'b0;
      wait_until(b + 5);  a_dma_req = 1'b1;
      wait_until(b + 6);  phase_a(1'b1);
      wait_until(b + 8);  a_dma_req = 1'b0;
      wait_until(b + 10); phase_a(1'b0);
      wait_until(b + 13);

      // Asynchronous reset in the middle of a burst, between clock edges.
      b = cyc;
      push_a(b + 1, s_halt(8'd3, 1'b0));
      push_a(b + 4, s_dma(8'd3, 1'b0));
      push_a(b + 7, s_idle(8'd0, 1'b0));
      a_dma_req = 1'b1;
      wait_until(b + 2);  phase_a(1'b1);
      wait_until(b + 7);
      #2 reset_n = 1'b0;
      #1;
      check("areset_dma_gnt", 32'(a_dma_gnt), 32'd0);
      check("areset_halt_b", 32'(a_halt_b), 32'd1);
      check("areset_memclk_sel", 32'(a_memclk_sel), 32'd0);
      check("areset_dma_len", 32'(a_dma_len), 32'd0);
      a_dma_req = 1'b0;
      tick();
      reset_n = 1'b1;
      wait_until(b + 11);

      // SETTLE=0, TIMEOUT=8: dma_done together with the limit counts as done, no flag.
      b = cyc;
      push_b(b + 1,  s_halt(8'd0, 1'b0));
      push_b(b + 2,  s_dma(8'd0, 1'b0));
      push_b(b + 10, s_halt(8'd8, 1'b0));
      push_b(b + 12, s_idle(8'd8, 1'b0));
      b_dma_req = 1'b1;
      wait_until(b + 1);  phase_b(1'b1);
      wait_until(b + 9);  b_dma_done = 1'b1; tick(); b_dma_done = 1'b0; b_dma_req = 1'b0;
      wait_until(b + 11); phase_b(1'b0);
      wait_until(b + 14);

      // Timeout: grant held exactly 8 cycles, sticky flag set; stray dma_done ignored.
      b = cyc;
      push_b(b + 1,  s_halt(8'd8, 1'b0));
      push_b(b + 3,  s_dma(8'd8, 1'b0));
      push_b(b + 11, s_halt(8'd8, 1'b1));
      push_b(b + 14, s_idle(8'd8, 1'b1));
      b_dma_req = 1'b1;
      wait_until(b + 2);  phase_b(1'b1);
      wait_until(b + 11); b_dma_req = 1'b0;
      wait_until(b + 12); b_dma_done = 1'b1; tick(); b_dma_done = 1'b0;
      phase_b(1'b1);
      wait_until(b + 16);

      // Later normal burst leaves the timeout flag set.
      b = cyc;
      push_b(b + 1, s_halt(8'd8, 1'b1));
      push_b(b + 2, s_dma(8'd8, 1'b1));
      push_b(b + 4, s_halt(8'd2, 1'b1));
      push_b(b + 6, s_idle(8'd2, 1'b1));
      b_dma_req = 1'b1;
      wait_until(b + 1); phase_b(1'b1);
      wait_until(b + 3); b_dma_done = 1'b1; tick(); b_dma_done = 1'b0; b_dma_req = 1'b0;
      wait_until(b + 5); phase_b(1'b0);
      wait_until(b + 9);

      check("a_pending_events", 32'(qa.size()), 32'd0);
      check("b_pending_events", 32'(qb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Sequences ownership of the shared system address/data bus between the 6502 core, MARIA DMA and the cartridge/RAM loader. It sits beside `maria` in the `Atari7800` top level. It halts the CPU at a legal cycle boundary, grants the bus to DMA and switches the memory clock to the fast clock during DMA. When DMA ends it hands the bus back to the CPU aligned to a CPU cycle. It replaces the ad-hoc `halt_b`/`drive_AB`/`memclk` muxing with one registered state machine.

## Interface
Parameters:
- `SETTLE`, default 1: sysclk cycles between the CPU boundary being accepted and the DMA grant (range 0–7).
- `TIMEOUT`, default 255: maximum granted DMA cycles before a forced release (range 1–255).

Ports:
- `sysclk`  in  1  7.16 MHz system clock; the only clock.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `cpu_phase`  in  1  One-sysclk strobe marking the end of a CPU bus cycle (pclk_0 fall).
- `cpu_rw`  in  1  CPU R/W of the cycle ending at `cpu_phase` (1 = read).
- `dma_req`  in  1  MARIA bus request; level, held until `dma_done`.
- `dma_done`  in  1  One-cycle pulse on MARIA's last DMA access.
- `load_req`  in  1  Loader request; level; highest priority.
- `halt_b`  out  1  Active-low CPU halt.
- `dma_gnt`  out  1  MARIA owns AB (selects `maria_AB_out`).
- `load_gnt`  out  1  Loader owns the bus.
- `owner`  out  2  Current owner: 0 = CPU, 1 = DMA, 2 = LOAD.
- `memclk_sel`  out  1  1 = memories clocked by sysclk; 0 = by pclk_0.
- `dma_len`  out  8  Granted cycle count of the last completed DMA burst, saturating at 255.
- `dma_timeout`  out  1  Sticky flag: a burst hit `TIMEOUT`.

## Operation
- All outputs are registered and decoded from the state register.
- Reset values: `halt_b`=1, `dma_gnt`=0, `load_gnt`=0, `owner`=0, `memclk_sel`=0, `dma_len`=0, `dma_timeout`=0. State = CPU.

States:
- **CPU**: `halt_b`=1.
  - `load_req` → LOAD.
  - Else `dma_req` → HALT_WAIT.
- **HALT_WAIT**: `halt_b`=0.
  - `cpu_phase`&`cpu_rw` → SETTLE with settle counter loaded to `SETTLE`; if `SETTLE`=0, go directly to DMA.
  - `cpu_phase`&~`cpu_rw` is ignored, because the 6502 cannot stop on a write.
  - `dma_req` deasserting → HANDBACK.
- **SETTLE**: `halt_b`=0. Counter decrements each cycle; at 1 → DMA.
- **DMA**: `halt_b`=0, `dma_gnt`=1, `memclk_sel`=1, `owner`=1.
  - The 8-bit burst counter starts at 1 on entry and increments each cycle, saturating.
  - `dma_done`, or counter = `TIMEOUT` with no `dma_done` → HANDBACK.
  - On exit, `dma_len` ← counter.
  - Timeout without `dma_done` sets `dma_timeout`; it clears only on reset.
- **HANDBACK**: `halt_b`=0, `dma_gnt`=0, `memclk_sel`=0, `owner`=0. Next `cpu_phase` → CPU.
- **LOAD**: `load_gnt`=1, `memclk_sel`=1, `owner`=2, `halt_b`=1. `load_req`=0 → CPU.

Priority and simultaneous events:
- `load_req` preempts from every state on the next cycle.
- If preempted from DMA, `dma_len` captures the partial count and `dma_timeout` is unchanged.
- `dma_done` and timeout in the same cycle: treated as done, no flag.
- `dma_req` rising during HANDBACK: ignored until CPU is re-entered.
- In CPU, a new request is honoured the next cycle.
- `dma_done` outside DMA is ignored.

## Timing
- CPU→HALT_WAIT: `halt_b` falls 1 cycle after `dma_req` is sampled high.
- Grant latency after the accepted `cpu_phase`: `dma_gnt` rises `SETTLE`+1 cycles later (1 cycle when `SETTLE`=0).
- `dma_gnt` and `memclk_sel` change in the same cycle, so there are no glitch cycles where they disagree.
- `dma_gnt` falls 1 cycle after `dma_done`.
- `halt_b` rises 1 cycle after the first `cpu_phase` seen in HANDBACK. A `cpu_phase` in the same cycle as `dma_done` does not count.
- `load_gnt` rises 1 cycle after `load_req`; `dma_gnt` falls in that same cycle.
- `reset_n` low mid-burst: all outputs return to reset values immediately (asynchronously); the counters clear.

## Test plan
- Basic burst, `SETTLE`=1: `dma_req`↑ at t0, `cpu_phase`+read at t4, `dma_done` at t20 → `halt_b`↓ t1, `dma_gnt`↑ t6, `dma_gnt`↓ t21, `halt_b`↑ after the next `cpu_phase`, `dma_len`=15.
- Write boundary: the first `cpu_phase` has `cpu_rw`=0 and the second `cpu_rw`=1 → grant is referenced to the second strobe only.
- Timeout, `TIMEOUT`=8: `dma_done` never asserted → `dma_gnt` high for exactly 8 cycles, `dma_len`=8, `dma_timeout`=1 and stays 1 after later normal bursts.
- Load preempt: `load_req`↑ on the 3rd DMA cycle → next cycle `dma_gnt`=0, `load_gnt`=1, `owner`=2, `dma_len`=3. `load_req`↓ → `owner`=0, `halt_b`=1.
- Request withdrawn: `dma_req`↓ in HALT_WAIT → `dma_gnt` never asserts; `halt_b` returns to 1 after the next `cpu_phase`.
- Async reset: `reset_n`↓ mid-DMA between clock edges → `dma_gnt`=0, `halt_b`=1, `memclk_sel`=0 without a clock edge; `dma_len`=0.
